// File: rtl/mad_io_if.sv
// Bundles the host-side FIFO handshakes and the processor In/Out/Int pins of mad_io_device.
// The device uses the slave modport; the host/processor side uses master.
interface mad_io_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] host_wdata;
    logic             host_wvalid;
    logic             host_wready;
    logic [WIDTH-1:0] host_rdata;
    logic             host_rvalid;
    logic             host_rready;
    logic [WIDTH-1:0] In;
    logic             in_rd;
    logic [WIDTH-1:0] Out;
    logic             out_wr;
    logic             Int;
    logic             tx_ovf;
    logic             rx_unf;

    modport master (
        output host_wdata, host_wvalid, host_rready, in_rd, Out, out_wr,
        input  host_wready, host_rdata, host_rvalid, In, Int, tx_ovf, rx_unf
    );

    modport slave (
        input  host_wdata, host_wvalid, host_rready, in_rd, Out, out_wr,
        output host_wready, host_rdata, host_rvalid, In, Int, tx_ovf, rx_unf
    );
endinterface

// File: rtl/mad_io_device.sv
// Processor-side I/O peripheral: RX FIFO feeding In, TX FIFO capturing Out, and an
// interrupt FSM that pulses Int once per word the processor must consume.
module mad_io_device #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int INT_LEN = 2
) (
    input  logic     Clk,
    input  logic     Rst,
    mad_io_if.slave  bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int CNTW = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;
    localparam logic [CW-1:0]   FULL     = CW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(INT_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT} state_t;

    logic [WIDTH-1:0] rx_mem_q [DEPTH];
    logic [WIDTH-1:0] tx_mem_q [DEPTH];
    logic [PW-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [PW-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic             rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d;
    logic             rx_empty, rx_full, tx_empty, tx_full;
    logic             rx_push, rx_pop, tx_push, tx_pop;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             int_q, int_d;

    always_comb begin
        rx_empty = (rx_cnt_q == '0);
        rx_full  = (rx_cnt_q == FULL);
        tx_empty = (tx_cnt_q == '0);
        tx_full  = (tx_cnt_q == FULL);
        // Full refuses a push even when a pop lands in the same cycle.
        rx_push  = bus.host_wvalid && !rx_full;
        rx_pop   = bus.in_rd && !rx_empty;
        tx_push  = bus.out_wr && !tx_full;
        tx_pop   = bus.host_rready && !tx_empty;

        rx_wr_d  = rx_push ? rx_wr_q + 1'b1 : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + 1'b1 : rx_rd_q;
        tx_wr_d  = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + 1'b1 : tx_rd_q;

        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        rx_unf_d = rx_unf_q | (bus.in_rd & rx_empty);
        tx_ovf_d = tx_ovf_q | (bus.out_wr & tx_full);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            rx_unf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else begin
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            rx_unf_q <= rx_unf_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    // Storage needs no reset: empty FIFOs mask their contents on the outputs.
    always_ff @(posedge Clk) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= bus.host_wdata;
        if (tx_push) tx_mem_q[tx_wr_q] <= bus.Out;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            int_q   <= int_d;
        end
    end

    // seen_q remembers an in_rd that arrived while the pulse was still running.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_empty) begin
                    state_d = S_PULSE;
                    cnt_d   = CNT_INIT;
                    seen_d  = 1'b0;
                end
            end
            S_PULSE: begin
                seen_d = seen_q | bus.in_rd;
                if (cnt_q == '0) state_d = S_WAIT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WAIT: begin
                if (seen_q || bus.in_rd) begin
                    state_d = S_IDLE;
                    seen_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        int_d = (state_d == S_PULSE);
    end

    assign bus.In          = rx_empty ? '0 : rx_mem_q[rx_rd_q];
    assign bus.host_wready = !rx_full;
    assign bus.host_rdata  = tx_empty ? '0 : tx_mem_q[tx_rd_q];
    assign bus.host_rvalid = !tx_empty;
    assign bus.Int         = int_q;
    assign bus.tx_ovf      = tx_ovf_q;
    assign bus.rx_unf      = rx_unf_q;
endmodule

// File: tb/tb_mad_io_device.sv
// Randomized and directed bench for mad_io_device, checked every cycle against a
// queue-based model of the two FIFOs and a timer view of the interrupt rules.
module tb_mad_io_device;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int INT_LEN = 2;

    logic Clk = 1'b0;
    logic Rst;
    mad_io_if #(.WIDTH(WIDTH)) bus ();

    mad_io_device #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INT_LEN(INT_LEN)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: word queues plus interrupt timing in plain cycle counts.
    logic [WIDTH-1:0] rx_q[$];
    logic [WIDTH-1:0] tx_q[$];
    bit m_ovf, m_unf;
    int rem_high;      // cycles of Int still to come in the current pulse
    bit need_consume;  // pulse finished, waiting for the processor to read
    bit consumed;      // an in_rd already happened since the pulse began

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        m_ovf = 0;
        m_unf = 0;
        rem_high = 0;
        need_consume = 0;
        consumed = 0;
    endtask

    task automatic model_edge();
        bit rx_has;
        bit do_rx_pop, do_rx_push, do_tx_pop, do_tx_push;
        rx_has = (rx_q.size() > 0);
        if (rem_high > 0) begin
            if (bus.in_rd) consumed = 1;
            rem_high--;
            if (rem_high == 0) need_consume = 1;
        end else if (need_consume) begin
            if (bus.in_rd || consumed) begin
                need_consume = 0;
                consumed = 0;
            end
        end else if (rx_has) begin
            rem_high = INT_LEN;
            consumed = 0;
        end
        do_rx_pop  = bus.in_rd && rx_q.size() > 0;
        do_rx_push = bus.host_wvalid && rx_q.size() < DEPTH;
        do_tx_pop  = bus.host_rready && tx_q.size() > 0;
        do_tx_push = bus.out_wr && tx_q.size() < DEPTH;
        if (bus.in_rd && rx_q.size() == 0) m_unf = 1;
        if (bus.out_wr && tx_q.size() == DEPTH) m_ovf = 1;
        if (do_rx_pop)  void'(rx_q.pop_front());
        if (do_rx_push) rx_q.push_back(bus.host_wdata);
        if (do_tx_pop)  void'(tx_q.pop_front());
        if (do_tx_push) tx_q.push_back(bus.Out);
    endtask

    task automatic check_all();
        chk("In",          int'(bus.In),          rx_q.size() > 0 ? int'(rx_q[0]) : 0);
        chk("host_wready", int'(bus.host_wready), int'(rx_q.size() < DEPTH));
        chk("host_rvalid", int'(bus.host_rvalid), int'(tx_q.size() > 0));
        chk("host_rdata",  int'(bus.host_rdata),  tx_q.size() > 0 ? int'(tx_q[0]) : 0);
        chk("Int",         int'(bus.Int),         int'(rem_high > 0));
        chk("tx_ovf",      int'(bus.tx_ovf),      int'(m_ovf));
        chk("rx_unf",      int'(bus.rx_unf),      int'(m_unf));
    endtask

    task automatic set_in(input bit wv, input logic [WIDTH-1:0] wd, input bit rr,
                          input bit ird, input bit owr, input logic [WIDTH-1:0] od);
        bus.host_wvalid = wv;
        bus.host_wdata  = wd;
        bus.host_rready = rr;
        bus.in_rd       = ird;
        bus.out_wr      = owr;
        bus.Out         = od;
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic apply(input bit wv, input logic [WIDTH-1:0] wd, input bit rr,
                         input bit ird, input bit owr, input logic [WIDTH-1:0] od);
        set_in(wv, wd, rr, ird, owr, od);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, '0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        set_in(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all();
        Rst = 1'b0;
        set_in(0, '0, 0, 0, 0, '0);
    endtask

    initial begin
        Rst = 1'b1;
        set_in(0, '0, 0, 0, 0, '0);
        model_reset();

        do_reset();

        // Single word: pulse, wait for consume, return to idle without re-firing.
        apply(1, 16'h0020, 0, 0, 0, '0);
        idle(6);
        apply(0, '0, 0, 1, 0, '0);
        idle(4);

        // Two words, one pulse per in_rd.
        apply(1, 16'hFFFF, 0, 0, 0, '0);
        apply(1, 16'hF320, 0, 0, 0, '0);
        idle(5);
        apply(0, '0, 0, 1, 0, '0);
        idle(5);
        apply(0, '0, 0, 1, 0, '0);
        idle(4);

        // RX fill, refused ninth push, drain across the pointer wrap, underflow.
        for (int i = 0; i < DEPTH; i++) apply(1, 16'(i), 0, 0, 0, '0);
        apply(1, 16'hAABD, 0, 0, 0, '0);
        for (int i = 0; i <= DEPTH; i++) apply(0, '0, 0, 1, 0, '0);
        idle(4);

        do_reset();

        // TX overflow, then host drains in order.
        for (int i = 0; i <= DEPTH; i++) apply(0, '0, 0, 0, 1, 16'(16'h1000 + i));
        for (int i = 0; i < DEPTH; i++) apply(0, '0, 1, 0, 0, '0);
        idle(1);

        do_reset();

        // TX full with concurrent push and pop: pop wins, push dropped.
        for (int i = 0; i < DEPTH; i++) apply(0, '0, 0, 0, 1, 16'(16'h2000 + i));
        apply(0, '0, 1, 0, 1, 16'h2BAD);
        for (int i = 0; i < DEPTH; i++) apply(0, '0, 1, 0, 0, '0);

        // in_rd during the pulse empties RX: no re-fire afterwards.
        do_reset();
        apply(1, 16'h0055, 0, 0, 0, '0);
        idle(1);
        apply(0, '0, 0, 1, 0, '0);
        idle(5);

        // Async reset mid-pulse drops Int before the next edge.
        do_reset();
        apply(1, 16'h0077, 0, 0, 0, '0);
        idle(1);
        chk("int_before_rst", int'(bus.Int), 1);
        #2;
        Rst = 1'b1;
        #1;
        chk("int_async_rst", int'(bus.Int), 0);
        chk("in_async_rst", int'(bus.In), 0);
        model_reset();
        @(posedge Clk);
        #1;
        check_all();
        Rst = 1'b0;

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            apply(($urandom_range(0, 2) == 0), 16'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), 16'($urandom));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
